battle_sequencer: RTL and testbench

Turn controller for the battle datapath. Sequences the game through menu, player-attack, bullet-dodge and end phases, owns player and monster HP, and gates the bullet engine run enable. Takes UART key codes, the collision flag and bullet damage, and drives HP values and phase to the renderer.

---
 rtl/battle_pkg.sv | 31 +++
 rtl/battle_tick_timer.sv | 47 ++++
 rtl/battle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_battle_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// ============================================================================
// Module      : battle_pkg
// Description : Shared state encoding, UART key codes and saturating math
//               for the battle turn controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package battle_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MENU  = 3'd1;
    localparam logic [2:0] PATK  = 3'd2;
    localparam logic [2:0] CHKM  = 3'd3;
    localparam logic [2:0] DODGE = 3'd4;
    localparam logic [2:0] CHKP  = 3'd5;
    localparam logic [2:0] WIN   = 3'd6;
    localparam logic [2:0] LOSE  = 3'd7;

    localparam logic [7:0] KEY_ENTER   = 8'h0D;
    localparam logic [7:0] KEY_SPACE   = 8'h20;
    localparam logic [7:0] KEY_FIGHT   = 8'h66;
    localparam logic [7:0] KEY_RESTART = 8'h72;

    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/battle_tick_timer.sv
// ============================================================================
// Module      : battle_tick_timer
// Description : Loadable 8-bit down-counter stepped by the game tick.
//               done_o is high when the count is zero or reaches zero on
//               the current tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module battle_tick_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       clr_i,
    input  logic       tick_i,
    output logic       done_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (clr_i) begin
            count_d = 8'd0;
        end else if (tick_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of load_i so a hit can reload the timer without a loop.
    assign done_o = (count_q == 8'd0) || (tick_i && (count_q == 8'd1));

endmodule

`default_nettype wire

// File: rtl/battle_sequencer.sv
// ============================================================================
// Module      : battle_sequencer
// Description : Battle turn FSM: menu, attack, dodge and end phases, HP
//               bookkeeping and bullet engine gating.
//               Optional macro BATTLE_IFRAME_EN adds post-hit invulnerability.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module battle_sequencer
    import battle_pkg::*;
#(
    parameter int DODGE_TICKS  = 100,
    parameter int P_HP_MAX     = 100,
    parameter int MON_HP_MAX   = 100,
    parameter int IFRAME_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [7:0] key,
    input  logic       hit,
    input  logic [7:0] hit_dmg,
    input  logic [7:0] atk_dmg,
    output logic       bullet_run,
    output logic [7:0] p_hp,
    output logic [7:0] mon_hp,
    output logic [2:0] phase,
    output logic [2:0] wave_idx,
    output logic       game_over,
    output logic       victory
);

    localparam logic [7:0] c_DODGE_LOAD = 8'(DODGE_TICKS);
    localparam logic [7:0] c_P_HP_MAX   = 8'(P_HP_MAX);
    localparam logic [7:0] c_MON_HP_MAX = 8'(MON_HP_MAX);

    logic [2:0] state_q,  state_d;
    logic [7:0] p_hp_q,   p_hp_d;
    logic [7:0] mon_hp_q, mon_hp_d;
    logic [2:0] wave_q,   wave_d;
    logic       bullet_run_q, game_over_q, victory_q;
    logic       hit_q;

    logic w_in_dodge;
    logic w_dodge_tick;
    logic w_hit_rise;
    logic w_hit_take;
    logic w_dodge_done;

    assign w_in_dodge   = (state_q == DODGE);
    assign w_dodge_tick = tick && w_in_dodge;
    assign w_hit_rise   = hit && !hit_q;

    battle_tick_timer u_dodge_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (state_q == CHKM),
        .load_val_i (c_DODGE_LOAD),
        .clr_i      (!w_in_dodge),
        .tick_i     (w_dodge_tick),
        .done_o     (w_dodge_done)
    );

`ifdef BATTLE_IFRAME_EN
    logic w_iframe_done;

    battle_tick_timer u_iframe_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_hit_take),
        .load_val_i (8'(IFRAME_TICKS)),
        .clr_i      (!w_in_dodge),
        .tick_i     (w_dodge_tick),
        .done_o     (w_iframe_done)
    );

    assign w_hit_take = w_in_dodge && w_hit_rise && w_iframe_done;
`else
    assign w_hit_take = w_in_dodge && w_hit_rise;
`endif

    always_comb begin
        state_d  = state_q;
        p_hp_d   = p_hp_q;
        mon_hp_d = mon_hp_q;
        wave_d   = wave_q;
        case (state_q)
            IDLE: begin
                if (key_valid && ((key == KEY_ENTER) || (key == KEY_SPACE))) begin
                    state_d = MENU;
                end
            end
            MENU: begin
                if (key_valid && (key == KEY_FIGHT)) begin
                    state_d = PATK;
                end
            end
            PATK: begin
                mon_hp_d = sat_sub8(mon_hp_q, atk_dmg);
                state_d  = CHKM;
            end
            CHKM: begin
                state_d = (mon_hp_q == 8'd0) ? WIN : DODGE;
            end
            DODGE: begin
                if (w_hit_take) begin
                    p_hp_d = sat_sub8(p_hp_q, hit_dmg);
                end
                // A hit landing with the final tick is applied before leaving.
                if (w_dodge_done || (p_hp_d == 8'd0)) begin
                    state_d = CHKP;
                end
            end
            CHKP: begin
                if (p_hp_q == 8'd0) begin
                    state_d = LOSE;
                end else begin
                    wave_d  = wave_q + 3'd1;
                    state_d = MENU;
                end
            end
            WIN, LOSE: begin
                if (key_valid && (key == KEY_RESTART)) begin
                    p_hp_d   = c_P_HP_MAX;
                    mon_hp_d = c_MON_HP_MAX;
                    wave_d   = 3'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            p_hp_q       <= c_P_HP_MAX;
            mon_hp_q     <= c_MON_HP_MAX;
            wave_q       <= 3'd0;
            bullet_run_q <= 1'b0;
            game_over_q  <= 1'b0;
            victory_q    <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_hp_q       <= p_hp_d;
            mon_hp_q     <= mon_hp_d;
            wave_q       <= wave_d;
            bullet_run_q <= (state_d == DODGE);
            game_over_q  <= (state_d == LOSE);
            victory_q    <= (state_d == WIN);
            hit_q        <= hit;
        end
    end

    assign bullet_run = bullet_run_q;
    assign p_hp       = p_hp_q;
    assign mon_hp     = mon_hp_q;
    assign phase      = state_q;
    assign wave_idx   = wave_q;
    assign game_over  = game_over_q;
    assign victory    = victory_q;

endmodule

`default_nettype wire

// File: tb/tb_battle_sequencer.sv
// ============================================================================
// Module      : tb_battle_sequencer
// Description : Directed self-checking bench for battle_sequencer; expected
//               HP values adapt to BATTLE_IFRAME_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_battle_sequencer;

`ifdef BATTLE_IFRAME_EN
    localparam bit c_IFR = 1'b1;
`else
    localparam bit c_IFR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key = 8'h00;
    logic       hit = 1'b0;
    logic [7:0] hit_dmg = 8'h00;
    logic [7:0] atk_dmg = 8'h00;
    logic       bullet_run;
    logic [7:0] p_hp;
    logic [7:0] mon_hp;
    logic [2:0] phase;
    logic [2:0] wave_idx;
    logic       game_over;
    logic       victory;

    int n_cmp = 0;
    int n_err = 0;

    battle_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key_valid  (key_valid),
        .key        (key),
        .hit        (hit),
        .hit_dmg    (hit_dmg),
        .atk_dmg    (atk_dmg),
        .bullet_run (bullet_run),
        .p_hp       (p_hp),
        .mon_hp     (mon_hp),
        .phase      (phase),
        .wave_idx   (wave_idx),
        .game_over  (game_over),
        .victory    (victory)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       kv;
        logic [7:0] k;
        logic       tk;
        logic [7:0] atk;
        logic [2:0] ph;
        logic [7:0] php;
        logic [7:0] mhp;
        logic       br;
        logic [2:0] wv;
        logic       go;
        logic       vi;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // {phase, p_hp, mon_hp, bullet_run, wave_idx, game_over, victory}
    task automatic chk_all(input string nm, input logic [2:0] ph, input logic [7:0] php,
                           input logic [7:0] mhp, input logic br, input logic [2:0] wv,
                           input logic go, input logic vi);
        chk(nm, {7'd0, phase, p_hp, mon_hp, bullet_run, wave_idx, game_over, victory},
                {7'd0, ph, php, mhp, br, wv, go, vi});
    endtask

    task automatic step(input logic r, input logic kv, input logic [7:0] k, input logic tk);
        @(negedge clk);
        reset = r;
        key_valid = kv;
        key = k;
        tick = tk;
        @(posedge clk);
        #1;
        reset = 1'b0;
        key_valid = 1'b0;
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic tick_n(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic press(input logic [7:0] k);
        step(1'b0, 1'b1, k, 1'b0);
    endtask

    task automatic set_hit(input logic v, input logic [7:0] d);
        @(negedge clk);
        hit = v;
        hit_dmg = d;
    endtask

    task automatic wait_phase(input string nm, input logic [2:0] ph, input int budget);
        for (int i = 0; (i < budget) && (phase !== ph); i++) begin
            idle(1);
        end
        chk(nm, {29'd0, phase}, {29'd0, ph});
    endtask

    task automatic round(input logic [7:0] atk);
        atk_dmg = atk;
        press(8'h66);
        wait_phase("round_dodge", 3'd4, 5);
        tick_n(100);
        wait_phase("round_menu", 3'd1, 5);
    endtask

    logic [7:0] exp_p;

    initial begin
        //          rst  kv    key    tk   atk    ph    php    mhp   br  wv    go  vi
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'd0,  3'd0, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h41, 1'b0, 8'd0,  3'd0, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h0D, 1'b0, 8'd0,  3'd1, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h20, 1'b0, 8'd0,  3'd1, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h72, 1'b0, 8'd0,  3'd1, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h66, 1'b0, 8'd30, 3'd2, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd30, 3'd3, 8'd100, 8'd70,  1'b0, 3'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd30, 3'd4, 8'd100, 8'd70,  1'b1, 3'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 8'h66, 1'b0, 8'd30, 3'd4, 8'd100, 8'd70,  1'b1, 3'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'd30, 3'd4, 8'd100, 8'd70,  1'b1, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            atk_dmg = vecs[i].atk;
            step(vecs[i].rst, vecs[i].kv, vecs[i].k, vecs[i].tk);
            chk_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].php, vecs[i].mhp,
                    vecs[i].br, vecs[i].wv, vecs[i].go, vecs[i].vi);
        end

        // Finish the first dodge: one tick already spent by the table.
        tick_n(98);
        chk("dodge_last_tick_pending", {29'd0, phase}, 32'd4);
        tick_n(1);
        chk_all("dodge_expire_chkp", 3'd5, 8'd100, 8'd70, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(1);
        chk_all("chkp_to_menu", 3'd1, 8'd100, 8'd70, 1'b0, 3'd1, 1'b0, 1'b0);

        // Seven more clean dodges wrap wave_idx 1 -> 0.
        for (int r = 0; r < 7; r++) round(8'd0);
        chk("wave_wrap", {29'd0, wave_idx}, 32'd0);

        // Held hit counts once; later edges depend on invulnerability.
        atk_dmg = 8'd0;
        press(8'h66);
        wait_phase("hit_dodge", 3'd4, 5);
        set_hit(1'b1, 8'd20);
        idle(49);
        chk("hit_held_once", {24'd0, p_hp}, 32'd80);
        set_hit(1'b0, 8'd20);
        idle(2);
        tick_n(2);
        set_hit(1'b1, 8'd20);
        idle(2);
        set_hit(1'b0, 8'd20);
        idle(1);
        exp_p = c_IFR ? 8'd80 : 8'd60;
        chk("hit_second_edge", {24'd0, p_hp}, {24'd0, exp_p});
        tick_n(6);
        set_hit(1'b1, 8'd20);
        idle(2);
        set_hit(1'b0, 8'd20);
        idle(1);
        exp_p = c_IFR ? 8'd60 : 8'd40;
        chk("hit_third_edge", {24'd0, p_hp}, {24'd0, exp_p});
        tick_n(6);
        set_hit(1'b1, exp_p - 8'd10);
        idle(2);
        set_hit(1'b0, 8'd0);
        idle(1);
        chk("hit_to_ten", {24'd0, p_hp}, 32'd10);
        tick_n(6);
        set_hit(1'b1, 8'd25);
        idle(1);
        chk("hp_saturate", {24'd0, p_hp}, 32'd0);
        wait_phase("lose_phase", 3'd7, 4);
        chk_all("lose_state", 3'd7, 8'd0, 8'd70, 1'b0, 3'd0, 1'b1, 1'b0);
        set_hit(1'b0, 8'd0);
        press(8'h66);
        chk("lose_ignores_f", {29'd0, phase}, 32'd7);
        press(8'h72);
        chk_all("restart_from_lose", 3'd0, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0);

        // Hit arriving on the expiring tick is applied before leaving DODGE.
        press(8'h20);
        chk("space_to_menu", {29'd0, phase}, 32'd1);
        atk_dmg = 8'd50;
        press(8'h66);
        wait_phase("simul_dodge", 3'd4, 5);
        tick_n(99);
        @(negedge clk);
        hit = 1'b1;
        hit_dmg = 8'd20;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk_all("hit_and_expire", 3'd5, 8'd80, 8'd50, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(1);
        chk_all("after_simul", 3'd1, 8'd80, 8'd50, 1'b0, 3'd1, 1'b0, 1'b0);
        set_hit(1'b0, 8'd0);

        // Monster down to 20, then an overkill attack saturates to 0 -> WIN.
        round(8'd30);
        chk("mon_at_20", {24'd0, mon_hp}, 32'd20);
        atk_dmg = 8'd50;
        press(8'h66);
        wait_phase("win_phase", 3'd6, 5);
        chk_all("win_state", 3'd6, 8'd80, 8'd0, 1'b0, 3'd2, 1'b0, 1'b1);
        press(8'h72);
        chk_all("restart_from_win", 3'd0, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0);

        // Reset in the middle of a dodge.
        press(8'h0D);
        atk_dmg = 8'd10;
        press(8'h66);
        wait_phase("rst_dodge", 3'd4, 5);
        set_hit(1'b1, 8'd20);
        idle(1);
        set_hit(1'b0, 8'd0);
        tick_n(3);
        chk_all("pre_reset", 3'd4, 8'd80, 8'd90, 1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk_all("mid_dodge_reset", 3'd0, 8'd100, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule

`default_nettype wire
